// File: rtl/diff_scan_unit.sv
// diff_scan_unit: multi-cycle first-differing-bit locator.
// Latches a^b on accept, then scans CHUNK bits per cycle from the LSB or MSB
// end and reports the absolute index of the first differing bit plus an
// equality flag, with valid/ready handshakes on both command and result sides.
// Optional feature macro: DIFF_POPCNT_EN adds the popcnt (Hamming distance)
// output and turns the scan into a fixed-length full sweep.
module diff_scan_unit #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned CHUNK = 8,
    localparam int unsigned IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             msb_first,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IDXW-1:0]  idx,
    output logic             eq
`ifdef DIFF_POPCNT_EN
    ,
    output logic [IDXW:0]    popcnt
`endif
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             msb_q, msb_d;
    logic [KW-1:0]    k_q, k_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             eq_q, eq_d;
`ifdef DIFF_POPCNT_EN
    logic [IDXW:0]    pc_q, pc_d;
    logic             hit_q, hit_d;
    logic [IDXW:0]    chunk_cnt;
`endif

    logic             accept;
    logic             last_chunk;
    logic [IDXW-1:0]  chunk_base;
    logic [CHUNK-1:0] chunk_bits;
    logic             chunk_hit;
    logic [IDXW-1:0]  chunk_pos;

    assign start_ready = rst_n && (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign accept      = start_valid && start_ready;
    assign last_chunk  = (k_q == KW'(NCHUNK - 1));
    assign idx         = idx_q;
    assign eq          = eq_q;
`ifdef DIFF_POPCNT_EN
    assign popcnt      = pc_q;
`endif

    // Select the chunk under examination and locate its priority bit.
    always_comb begin
        if (msb_q) begin
            chunk_base = IDXW'((NCHUNK - 1 - 32'(k_q)) * CHUNK);
        end else begin
            chunk_base = IDXW'(32'(k_q) * CHUNK);
        end
        chunk_bits = x_q[chunk_base +: CHUNK];
        chunk_hit  = |chunk_bits;
        chunk_pos  = '0;
        if (msb_q) begin
            // Ascending sweep: the last set bit seen is the highest.
            for (int unsigned i = 0; i < CHUNK; i++) begin
                if (chunk_bits[i]) chunk_pos = IDXW'(i);
            end
        end else begin
            // Descending sweep: the last set bit seen is the lowest.
            for (int unsigned i = CHUNK; i > 0; i--) begin
                if (chunk_bits[i-1]) chunk_pos = IDXW'(i - 1);
            end
        end
    end

`ifdef DIFF_POPCNT_EN
    // Count set bits in the current chunk for the Hamming-distance accumulator.
    always_comb begin
        chunk_cnt = '0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            chunk_cnt = chunk_cnt + (IDXW + 1)'(chunk_bits[i]);
        end
    end
`endif

    // Next-state and datapath update for the IDLE/SCAN/DONE controller.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        msb_d   = msb_q;
        k_d     = k_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
`ifdef DIFF_POPCNT_EN
        pc_d    = pc_q;
        hit_d   = hit_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d     = a ^ b;
                    msb_d   = msb_first;
                    k_d     = '0;
`ifdef DIFF_POPCNT_EN
                    pc_d    = '0;
                    hit_d   = 1'b0;
`endif
                    state_d = SCAN;
                end
            end
            SCAN: begin
`ifdef DIFF_POPCNT_EN
                // Full sweep: idx keeps only the first hit in scan order.
                pc_d = pc_q + chunk_cnt;
                if (chunk_hit && !hit_q) begin
                    idx_d = chunk_base + chunk_pos;
                    hit_d = 1'b1;
                end
                if (last_chunk) begin
                    eq_d    = !(hit_q || chunk_hit);
                    if (!(hit_q || chunk_hit)) idx_d = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
`else
                if (chunk_hit) begin
                    idx_d   = chunk_base + chunk_pos;
                    eq_d    = 1'b0;
                    state_d = DONE;
                end else if (last_chunk) begin
                    idx_d   = '0;
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
`endif
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            msb_q   <= 1'b0;
            k_q     <= '0;
            idx_q   <= '0;
            eq_q    <= 1'b0;
`ifdef DIFF_POPCNT_EN
            pc_q    <= '0;
            hit_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            msb_q   <= msb_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
`ifdef DIFF_POPCNT_EN
            pc_q    <= pc_d;
            hit_q   <= hit_d;
`endif
        end
    end

endmodule

// File: tb/tb_diff_scan_unit.sv
// Self-checking bench for diff_scan_unit (WIDTH=32, CHUNK=8).
// Reference model works on the whole a^b word: it finds the lowest/highest set
// bit directly and derives the scan latency from the chunk that bit lives in.
module tb_diff_scan_unit;

    localparam int unsigned W  = 32;
    localparam int unsigned C  = 8;
    localparam int unsigned NC = W / C;
    localparam int unsigned IW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          msb_first = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [IW-1:0] idx;
    logic          eq;
`ifdef DIFF_POPCNT_EN
    logic [IW:0]   popcnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    diff_scan_unit #(.WIDTH(W), .CHUNK(C)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .msb_first   (msb_first),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .idx         (idx),
        .eq          (eq)
`ifdef DIFF_POPCNT_EN
        ,
        .popcnt      (popcnt)
`endif
    );

    // Behavioural reference: index of first differing bit, equality, latency, popcount.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mmsb,
                                  output logic [IW-1:0] eidx, output logic eeq,
                                  output int elat, output int epc);
        logic [W-1:0] x;
        int pos;
        x    = ma ^ mb;
        eidx = '0;
        eeq  = 1'b0;
        elat = NC;
        epc  = $countones(x);
        pos  = -1;
        if (x == '0) begin
            eeq = 1'b1;
        end else if (mmsb) begin
            for (int i = 0; i < W; i++) if (x[i]) pos = i;
            eidx = IW'(pos);
            elat = NC - pos / C;
        end else begin
            for (int i = W - 1; i >= 0; i--) if (x[i]) pos = i;
            eidx = IW'(pos);
            elat = pos / C + 1;
        end
`ifdef DIFF_POPCNT_EN
        elat = NC;
`endif
    endfunction

    // Drive one command, measure latency, capture the result, then consume it.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tm,
                          output int lat, output logic [IW-1:0] ridx, output logic req,
                          output int rpc, output logic rdy_cmd, output logic timed_out);
        @(negedge clk);
        a = ta; b = tb_v; msb_first = tm; start_valid = 1'b1;
        rdy_cmd = start_ready;
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = $urandom; b = $urandom; msb_first = 1'($urandom_range(0, 1));
        lat = 0;
        timed_out = 1'b0;
        while (!res_valid && !timed_out) begin
            @(posedge clk); #1;
            lat++;
            if (lat > NC + 4) timed_out = 1'b1;
        end
        ridx = idx;
        req  = eq;
`ifdef DIFF_POPCNT_EN
        rpc = int'(popcnt);
`else
        rpc = 0;
`endif
        @(negedge clk); res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL reset_start_ready: got %b expected 0", start_ready); end
        checks++; if (idx !== '0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", idx); end
        checks++; if (eq !== 1'b0) begin errors++; $display("FAIL reset_eq: got %b expected 0", eq); end
`ifdef DIFF_POPCNT_EN
        checks++; if (popcnt !== '0) begin errors++; $display("FAIL reset_popcnt: got %0d expected 0", popcnt); end
`endif
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL release_start_ready: got %b expected 1", start_ready); end
    endtask

    // Runs one op against the model and compares every observable.
    task automatic test_one(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tm);
        logic [IW-1:0] eidx, ridx;
        logic eeq, req, rdy, tmo;
        int elat, epc, lat, rpc;
        model(ta, tb_v, tm, eidx, eeq, elat, epc);
        run_op(ta, tb_v, tm, lat, ridx, req, rpc, rdy, tmo);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b expected 1", tag, rdy); end
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL %s_timeout: no res_valid within %0d edges", tag, NC + 4); end
        checks++; if (lat != elat) begin errors++; $display("FAIL %s_latency: got %0d expected %0d (a=%h b=%h msb=%b)", tag, lat, elat, ta, tb_v, tm); end
        checks++; if (ridx !== eidx) begin errors++; $display("FAIL %s_idx: got %0d expected %0d (a=%h b=%h msb=%b)", tag, ridx, eidx, ta, tb_v, tm); end
        checks++; if (req !== eeq) begin errors++; $display("FAIL %s_eq: got %b expected %b (a=%h b=%h)", tag, req, eeq, ta, tb_v); end
`ifdef DIFF_POPCNT_EN
        checks++; if (rpc != epc) begin errors++; $display("FAIL %s_popcnt: got %0d expected %0d (a=%h b=%h)", tag, rpc, epc, ta, tb_v); end
`endif
        checks++; if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
            errors++; $display("FAIL %s_after_handshake: got valid=%b ready=%b expected valid=0 ready=1", tag, res_valid, start_ready);
        end
    endtask

    task automatic test_directed();
        test_one("lsb_bit0",    32'h0000_0000, 32'h0000_0001, 1'b0);
        test_one("equal",       32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        test_one("msb_31",      32'h8000_0001, 32'h0000_0000, 1'b1);
        test_one("lsb_0",       32'h8000_0001, 32'h0000_0000, 1'b0);
        test_one("lsb_16",      32'h0000_0000, 32'h0001_0000, 1'b0);
        test_one("all_ones",    32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        test_one("lsb_top",     32'h0000_0000, 32'h8000_0000, 1'b0);
        test_one("msb_bottom",  32'h0000_0001, 32'h0000_0000, 1'b1);
        test_one("equal_msb",   32'h1234_5678, 32'h1234_5678, 1'b1);
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, one;
        one = 1;
        for (int n = 0; n < 60; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = ra;
                1:       rb = ra ^ (one << $urandom_range(0, W - 1));
                2:       rb = $urandom;
                3:       rb = ra ^ (one << $urandom_range(0, W - 1)) ^ (one << $urandom_range(0, W - 1));
                default: rb = ra ^ ($urandom & $urandom & $urandom);
            endcase
            test_one("random", ra, rb, 1'($urandom_range(0, 1)));
        end
    endtask

    // Result held under back-pressure while a new command waits.
    task automatic test_stall();
        logic [IW-1:0] eidx, eidx2;
        logic eeq, eeq2;
        int elat, epc, elat2, epc2, lat;
        model(32'h0, 32'h0000_0100, 1'b0, eidx, eeq, elat, epc);
        model(32'h0, 32'h0000_0004, 1'b0, eidx2, eeq2, elat2, epc2);
        @(negedge clk);
        a = 32'h0; b = 32'h0000_0100; msb_first = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'h0; b = 32'h0000_0004;
        lat = 0;
        while (!res_valid && lat <= NC + 4) begin @(posedge clk); #1; lat++; end
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL stall_timeout: no res_valid within %0d edges", NC + 4); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (res_valid !== 1'b1 || start_ready !== 1'b0) begin
                errors++; $display("FAIL stall_hold_ctl: got valid=%b ready=%b expected valid=1 ready=0", res_valid, start_ready);
            end
            checks++; if (idx !== eidx || eq !== eeq) begin
                errors++; $display("FAIL stall_hold_data: got idx=%0d eq=%b expected idx=%0d eq=%b", idx, eq, eidx, eeq);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
            errors++; $display("FAIL stall_no_same_cycle: got valid=%b ready=%b expected valid=0 ready=1", res_valid, start_ready);
        end
        @(posedge clk); #1;
        start_valid = 1'b0;
        checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL stall_accept_next: got ready=%b expected 0", start_ready); end
        lat = 0;
        while (!res_valid && lat <= NC + 4) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != elat2 || idx !== eidx2 || eq !== eeq2) begin
            errors++; $display("FAIL stall_next_result: got lat=%0d idx=%0d eq=%b expected lat=%0d idx=%0d eq=%b", lat, idx, eq, elat2, eidx2, eq2_str(eeq2));
        end
        @(negedge clk); res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;
    endtask

    function automatic logic eq2_str(input logic v);
        return v;
    endfunction

    // Reset in the middle of a scan discards the operation.
    task automatic test_abort();
        int seen;
        test_one("pre_abort", 32'hCAFE_0000, 32'hCAFE_0000, 1'b0);
        @(negedge clk);
        a = 32'h5555_AAAA; b = 32'h5555_AAAA; msb_first = 1'b1; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0 || start_ready !== 1'b0) begin
            errors++; $display("FAIL abort_immediate: got valid=%b ready=%b expected valid=0 ready=0", res_valid, start_ready);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (start_ready !== 1'b1 || idx !== '0 || eq !== 1'b0) begin
            errors++; $display("FAIL abort_release: got ready=%b idx=%0d eq=%b expected ready=1 idx=0 eq=0", start_ready, idx, eq);
        end
        seen = 0;
        for (int c = 0; c < NC + 2; c++) begin
            @(posedge clk); #1;
            if (res_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_result_lost: got %0d valid cycles expected 0", seen); end
        test_one("post_abort", 32'h0000_0000, 32'h0040_0000, 1'b1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
